// File: rtl/edge_seq_pkg.sv
// Shared definitions for the edge-counter measurement sequencer.
//   seq_state_t       : sequencer state encoding, also exposed for regmap readback
//   SEQ_STATE_W       : width of the state encoding
//   CLEAR_CYCLES_DEF  : default number of cycles cnt_clear is held
package edge_seq_pkg;

   localparam int SEQ_STATE_W      = 3;
   localparam int CLEAR_CYCLES_DEF = 2;

   typedef enum logic [SEQ_STATE_W-1:0] {
      SEQ_IDLE  = 3'd0,
      SEQ_CLEAR = 3'd1,
      SEQ_ARM   = 3'd2,
      SEQ_RUN   = 3'd3,
      SEQ_SNAP  = 3'd4,
      SEQ_DONE  = 3'd5
   } seq_state_t;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter that stops at zero. It is shared by the ARM timeout and
// the RUN window, which never overlap.
// Ports:
//   clk, rst_n_sync : clock, asynchronous active-low reset
//   load, load_val  : load has priority over enable
//   en              : decrement by one while non-zero
//   zero            : count is zero
module seq_down_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n_sync,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n_sync) begin
      if (!rst_n_sync) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/edge_counter_sequencer.sv
// Edge-counter measurement sequencer: clears the channels, optionally waits for
// a trigger, runs the counters for a fixed window and snapshots them.
// Optional feature macro: SEQ_AUTO_REARM_EN (SNAP loops back to CLEAR while
// cfg_rearm is set, and completed windows are counted in run_count).
// Ports:
//   clk, rst_n_sync          : clock, asynchronous active-low reset
//   start, abort             : single-cycle requests (abort wins)
//   cfg_enable, cfg_trig_enable, window_len, arm_timeout : latched on start
//   trig_in                  : synchronized per-channel trigger levels
//   cfg_rearm                : auto re-arm request (macro build only)
//   cnt_clear/run/snapshot   : per-channel counter strobes
//   trig_out                 : pulse in the first RUN cycle after a trigger hit
//   busy, done, timed_out    : status; seq_state is the raw state encoding
//   run_count                : completed windows (macro build only, else 0)
//
// state | meaning
// IDLE  | waiting for start
// CLEAR | cnt_clear held on active channels for CLEAR_CYCLES cycles
// ARM   | waiting for a masked trigger, optionally bounded by arm_timeout
// RUN   | cnt_run held for the window length
// SNAP  | one-cycle cnt_snapshot
// DONE  | measurement complete, done held until start or abort
module edge_counter_sequencer
   import edge_seq_pkg::*;
#(
   parameter int NUM_CH       = 4,
   parameter int CLEAR_CYCLES = CLEAR_CYCLES_DEF,
   parameter int WIN_W        = 32
) (
   input  logic                   clk,
   input  logic                   rst_n_sync,
   input  logic                   start,
   input  logic                   abort,
   input  logic [NUM_CH-1:0]      cfg_enable,
   input  logic [NUM_CH-1:0]      cfg_trig_enable,
   input  logic [NUM_CH-1:0]      trig_in,
   input  logic [WIN_W-1:0]       window_len,
   input  logic [WIN_W-1:0]       arm_timeout,
   input  logic                   cfg_rearm,
   output logic [NUM_CH-1:0]      cnt_clear,
   output logic [NUM_CH-1:0]      cnt_run,
   output logic [NUM_CH-1:0]      cnt_snapshot,
   output logic                   trig_out,
   output logic                   busy,
   output logic                   done,
   output logic                   timed_out,
   output logic [SEQ_STATE_W-1:0] seq_state,
   output logic [15:0]            run_count
);

   seq_state_t        state, state_nxt;
   logic [NUM_CH-1:0] act_mask, trg_mask;
   logic [WIN_W-1:0]  win_len, tmo_len;
   logic [3:0]        clr_cnt;
   logic              trig_pend, timed_out_r;
   logic              start_ok, hit, tmo_hit, clr_end;
   logic              tmr_load, tmr_en, tmr_zero;
   logic [WIN_W-1:0]  tmr_val;
   logic              rearm;

   assign start_ok = start && !abort && (cfg_enable != '0) &&
                     ((state == SEQ_IDLE) || (state == SEQ_DONE));
   assign hit      = (trig_in & trg_mask) != '0;
   // A trigger on the expiry cycle takes precedence over the timeout.
   assign tmo_hit  = (tmo_len != '0) && tmr_zero && !hit;
   assign clr_end  = (clr_cnt == 4'd0);
   assign tmr_en   = (state == SEQ_ARM) || (state == SEQ_RUN);

   always_ff @(posedge clk or negedge rst_n_sync) begin
      if (!rst_n_sync) begin
         state <= SEQ_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // The timer is loaded with length-1 so that the stage ends on the zero flag
   // after exactly "length" cycles; win_len is never 0, so RUN cannot wrap.
   always_comb begin
      state_nxt    = state;
      cnt_clear    = '0;
      cnt_run      = '0;
      cnt_snapshot = '0;
      tmr_load     = 1'b0;
      tmr_val      = win_len - WIN_W'(1);
      case (state)
         SEQ_IDLE, SEQ_DONE: begin
            if (start_ok) state_nxt = SEQ_CLEAR;
         end
         SEQ_CLEAR: begin
            cnt_clear = act_mask;
            if (clr_end) begin
               tmr_load = 1'b1;
               if (trg_mask != '0) begin
                  state_nxt = SEQ_ARM;
                  tmr_val   = tmo_len - WIN_W'(1);
               end else begin
                  state_nxt = SEQ_RUN;
               end
            end
         end
         SEQ_ARM: begin
            if (hit) begin
               state_nxt = SEQ_RUN;
               tmr_load  = 1'b1;
            end else if (tmo_hit) begin
               state_nxt = SEQ_DONE;
            end
         end
         SEQ_RUN: begin
            cnt_run = act_mask;
            if (tmr_zero) state_nxt = SEQ_SNAP;
         end
         SEQ_SNAP: begin
            cnt_snapshot = act_mask;
            state_nxt    = rearm ? SEQ_CLEAR : SEQ_DONE;
         end
         default: state_nxt = SEQ_IDLE;
      endcase
      if (abort) state_nxt = SEQ_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n_sync) begin
      if (!rst_n_sync) begin
         act_mask    <= '0;
         trg_mask    <= '0;
         win_len     <= '0;
         tmo_len     <= '0;
         clr_cnt     <= '0;
         trig_pend   <= 1'b0;
         timed_out_r <= 1'b0;
      end else begin
         if (start_ok) begin
            act_mask <= cfg_enable;
            trg_mask <= cfg_enable & cfg_trig_enable;
            win_len  <= (window_len == '0) ? WIN_W'(1) : window_len;
            tmo_len  <= arm_timeout;
         end
         if (abort || start_ok) begin
            timed_out_r <= 1'b0;
         end else if ((state == SEQ_ARM) && tmo_hit) begin
            timed_out_r <= 1'b1;
         end
         trig_pend <= (state == SEQ_ARM) && hit && !abort;
         // Reloaded whenever outside CLEAR, so every CLEAR entry starts full.
         if (state != SEQ_CLEAR) begin
            clr_cnt <= 4'(CLEAR_CYCLES - 1);
         end else if (!clr_end) begin
            clr_cnt <= clr_cnt - 4'd1;
         end
      end
   end

   seq_down_counter #(.W(WIN_W)) u_tmr (
      .clk        (clk),
      .rst_n_sync (rst_n_sync),
      .load       (tmr_load),
      .load_val   (tmr_val),
      .en         (tmr_en),
      .zero       (tmr_zero)
   );

`ifdef SEQ_AUTO_REARM_EN
   logic [15:0] run_cnt_r;

   assign rearm = cfg_rearm;

   always_ff @(posedge clk or negedge rst_n_sync) begin
      if (!rst_n_sync) begin
         run_cnt_r <= '0;
      end else if (abort || start_ok) begin
         run_cnt_r <= '0;
      end else if ((state == SEQ_SNAP) && (run_cnt_r != 16'hFFFF)) begin
         run_cnt_r <= run_cnt_r + 16'd1;
      end
   end

   assign run_count = run_cnt_r;
`else
   logic unused_rearm;

   assign unused_rearm = cfg_rearm;
   assign rearm        = 1'b0;
   assign run_count    = '0;
`endif

   assign trig_out  = (state == SEQ_RUN) && trig_pend;
   assign busy      = (state != SEQ_IDLE) && (state != SEQ_DONE);
   assign done      = (state == SEQ_DONE);
   assign timed_out = timed_out_r;
   assign seq_state = state;

endmodule

// File: tb/tb_edge_counter_sequencer.sv
// Directed self-checking bench for edge_counter_sequencer. Inputs are driven and
// outputs sampled on the falling clock edge; the design acts on the rising edge.
module tb_edge_counter_sequencer;
   import edge_seq_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n_sync = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [3:0]  cfg_enable = '0;
   logic [3:0]  cfg_trig_enable = '0;
   logic [3:0]  trig_in = '0;
   logic [31:0] window_len = '0;
   logic [31:0] arm_timeout = '0;
   logic        cfg_rearm = 1'b0;
   logic [3:0]  cnt_clear, cnt_run, cnt_snapshot;
   logic        trig_out, busy, done, timed_out;
   logic [2:0]  seq_state;
   logic [15:0] run_count;

   int n_chk = 0;
   int n_fail = 0;

   int          o_clr, o_run, o_snap, o_trg, o_arm;
   logic [3:0]  o_vclr, o_vrun, o_vsnap;
   logic [31:0] o_trace;

   edge_counter_sequencer dut (
      .clk             (clk),
      .rst_n_sync      (rst_n_sync),
      .start           (start),
      .abort           (abort),
      .cfg_enable      (cfg_enable),
      .cfg_trig_enable (cfg_trig_enable),
      .trig_in         (trig_in),
      .window_len      (window_len),
      .arm_timeout     (arm_timeout),
      .cfg_rearm       (cfg_rearm),
      .cnt_clear       (cnt_clear),
      .cnt_run         (cnt_run),
      .cnt_snapshot    (cnt_snapshot),
      .trig_out        (trig_out),
      .busy            (busy),
      .done            (done),
      .timed_out       (timed_out),
      .seq_state       (seq_state),
      .run_count       (run_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic do_abort();
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
   endtask

   task automatic wait_state(input string tag, input logic [2:0] s, input int max_cyc);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         if (seq_state == s) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check(tag, 32'(ok), 32'd1);
   endtask

   // Samples from the current falling edge until DONE or IDLE is reached,
   // accumulating strobe cycle counts and the sequence of visited states.
   task automatic observe(input string tag, input int max_cyc);
      logic [2:0] prev;
      bit fin;
      o_clr = 0; o_run = 0; o_snap = 0; o_trg = 0; o_arm = 0;
      o_vclr = '0; o_vrun = '0; o_vsnap = '0; o_trace = '0;
      prev = 3'h7;
      fin = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         if (i != 0) @(negedge clk);
         if (cnt_clear != '0) begin o_clr++; o_vclr |= cnt_clear; end
         if (cnt_run != '0) begin o_run++; o_vrun |= cnt_run; end
         if (cnt_snapshot != '0) begin o_snap++; o_vsnap |= cnt_snapshot; end
         if (trig_out) o_trg++;
         if (seq_state == SEQ_ARM) o_arm++;
         if (seq_state != prev) begin
            o_trace = {o_trace[27:0], 1'b0, seq_state};
            prev = seq_state;
         end
         if (seq_state == SEQ_DONE || seq_state == SEQ_IDLE) begin
            fin = 1'b1;
            break;
         end
      end
      check({tag, "_end"}, 32'(fin), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int arm_n;
      // ---- reset state
      #3;
      check("rst_state", 32'(seq_state), 32'd0);
      check("rst_strobes", 32'({cnt_clear, cnt_run, cnt_snapshot}), 32'd0);
      check("rst_status", 32'({trig_out, busy, done, timed_out}), 32'd0);
      check("rst_run_count", 32'(run_count), 32'd0);
      @(negedge clk);
      rst_n_sync = 1'b1;

      // ---- basic run, no trigger
      cfg_enable = 4'b0101; cfg_trig_enable = 4'b0000; window_len = 10; arm_timeout = 0;
      pulse_start();
      check("basic_clear_latency", 32'(seq_state), 32'(SEQ_CLEAR));
      check("basic_busy", 32'(busy), 32'd1);
      observe("basic", 40);
      check("basic_clr_cycles", o_clr, 2);
      check("basic_clr_mask", 32'(o_vclr), 32'h5);
      check("basic_run_cycles", o_run, 10);
      check("basic_run_mask", 32'(o_vrun), 32'h5);
      check("basic_snap_cycles", o_snap, 1);
      check("basic_snap_mask", 32'(o_vsnap), 32'h5);
      check("basic_trig_out", o_trg, 0);
      check("basic_trace", o_trace, 32'h1345);
      repeat (3) @(negedge clk);
      check("basic_done_held", 32'({done, busy, timed_out}), 32'b100);
      check("basic_run_count", 32'(run_count), 32'd0);

      // ---- trigger arm: channel 0 not trigger-enabled, channel 1 is
      cfg_enable = 4'hF; cfg_trig_enable = 4'b0010; window_len = 5;
      pulse_start();
      wait_state("trg_reach_arm", SEQ_ARM, 10);
      trig_in = 4'b0001;
      arm_n = 0;
      repeat (7) begin
         if (seq_state == SEQ_ARM) arm_n++;
         @(negedge clk);
      end
      check("trg_ch0_ignored", arm_n, 7);
      check("trg_still_arm", 32'(seq_state), 32'(SEQ_ARM));
      trig_in = 4'b0011;
      @(negedge clk);
      trig_in = 4'b0000;
      check("trg_run_next", 32'(seq_state), 32'(SEQ_RUN));
      observe("trg", 40);
      check("trg_trig_out_once", o_trg, 1);
      check("trg_run_cycles", o_run, 5);
      check("trg_trace", o_trace, 32'h345);

      // ---- ARM timeout
      cfg_enable = 4'hF; cfg_trig_enable = 4'hF; window_len = 5; arm_timeout = 20;
      pulse_start();
      observe("tmo", 60);
      check("tmo_arm_cycles", o_arm, 20);
      check("tmo_run_snap", o_run + o_snap, 0);
      check("tmo_trace", o_trace, 32'h125);
      check("tmo_flags", 32'({done, timed_out}), 32'b11);
      pulse_start();
      check("tmo_flag_clears", 32'({done, timed_out}), 32'b00);
      do_abort();
      check("tmo_abort_idle", 32'(seq_state), 32'(SEQ_IDLE));

      // ---- abort beats start during RUN
      cfg_enable = 4'hF; cfg_trig_enable = 4'h0; window_len = 10; arm_timeout = 0;
      pulse_start();
      wait_state("abrt_reach_run", SEQ_RUN, 10);
      abort = 1'b1; start = 1'b1;
      @(negedge clk);
      abort = 1'b0; start = 1'b0;
      check("abrt_state", 32'(seq_state), 32'(SEQ_IDLE));
      check("abrt_strobes", 32'({cnt_clear, cnt_run, cnt_snapshot, trig_out}), 32'd0);
      check("abrt_status", 32'({busy, done}), 32'd0);
      @(negedge clk);
      check("abrt_start_ignored", 32'(seq_state), 32'(SEQ_IDLE));

      // ---- start with no channels enabled
      cfg_enable = 4'h0;
      pulse_start();
      @(negedge clk);
      check("noen_idle", 32'({seq_state, cnt_clear}), 32'd0);

      // ---- zero window behaves as one cycle
      cfg_enable = 4'b0011; window_len = 0;
      pulse_start();
      observe("win0", 30);
      check("win0_run_cycles", o_run, 1);
      check("win0_run_mask", 32'(o_vrun), 32'h3);

      // ---- asynchronous reset during RUN
      cfg_enable = 4'hF; window_len = 10;
      pulse_start();
      wait_state("rst_reach_run", SEQ_RUN, 10);
      #2;
      rst_n_sync = 1'b0;
      #1;
      check("rstrun_state", 32'(seq_state), 32'd0);
      check("rstrun_outputs", 32'({cnt_clear, cnt_run, cnt_snapshot, trig_out, busy, done, timed_out}), 32'd0);
      @(negedge clk);
      rst_n_sync = 1'b1;

`ifdef SEQ_AUTO_REARM_EN
      begin
         logic [2:0] prev;
         logic [11:0] rc_trace;
         int pushes;
         int done_seen;
         cfg_enable = 4'hF; cfg_trig_enable = 4'h0; window_len = 3; cfg_rearm = 1'b1;
         pulse_start();
         prev = 3'h0; rc_trace = '0; pushes = 0; done_seen = 0;
         for (int i = 0; i < 100 && pushes < 3; i++) begin
            if (prev == SEQ_SNAP) begin
               rc_trace = {rc_trace[7:0], run_count[3:0]};
               pushes++;
               check("rearm_back_to_clear", 32'(seq_state), 32'(SEQ_CLEAR));
            end
            if (done) done_seen++;
            prev = seq_state;
            if (pushes < 3) @(negedge clk);
         end
         check("rearm_count_seq", 32'(rc_trace), 32'h123);
         check("rearm_no_done", done_seen, 0);
         cfg_rearm = 1'b0;
         wait_state("rearm_reach_done", SEQ_DONE, 40);
         check("rearm_final_count", 32'(run_count), 32'd4);
         check("rearm_done", 32'(done), 32'd1);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/edge_counter_sequencer.md
Name: edge_counter_sequencer

Overview:
- Sequences the four edge-counter channels through a measurement: clear, arm on trigger, count for a fixed window, snapshot.
- Sits between the SCARF edge-counter regmap and the four counter channels.
- Consumes the regmap cfg_enable/cfg_trig_enable fields.
- Drives per-channel clear/run/snapshot strobes and returns status bytes to the regmap.

Parameters:
- NUM_CH, 4, number of counter channels.
- CLEAR_CYCLES, 2, cycles cnt_clear is held (1..15).
- WIN_W, 32, width of window and arm-timeout counters.

Ports:
- clk  input  1  system clock
- rst_n_sync  input  1  asynchronous active-low reset
- start  input  1  single-cycle request to begin a measurement
- abort  input  1  single-cycle request to cancel a measurement
- cfg_enable  input  NUM_CH  channels taking part
- cfg_trig_enable  input  NUM_CH  channels whose trig_in may arm the window
- trig_in  input  NUM_CH  synchronized per-channel trigger levels
- window_len  input  WIN_W  RUN length in clk cycles
- arm_timeout  input  WIN_W  max ARM cycles; 0 = wait forever
- cfg_rearm  input  1  auto re-arm request (used only under the macro)
- cnt_clear  output  NUM_CH  counter clear strobe
- cnt_run  output  NUM_CH  counter count-enable
- cnt_snapshot  output  NUM_CH  counter shadow-latch strobe
- trig_out  output  1  one-cycle pulse when the window opens on a trigger
- busy  output  1  state not IDLE/DONE
- done  output  1  measurement complete
- timed_out  output  1  sticky flag: ARM timed out
- seq_state  output  3  state encoding for regmap readback
- run_count  output  16  completed windows (macro only)

Behaviour:
- Reset (async, rst_n_sync low): state IDLE; all strobes 0; trig_out, busy, done, timed_out = 0; run_count = 0; internal masks and counters = 0.
- A reset mid-operation drops every strobe immediately.
- State encoding: IDLE=0, CLEAR=1, ARM=2, RUN=3, SNAP=4, DONE=5.
- Outputs are a Moore decode of the registered state and the latched masks.
- start is accepted only in IDLE or DONE, and only if cfg_enable != 0.
  - On accept: act_mask <= cfg_enable; trg_mask <= cfg_enable & cfg_trig_enable; win <= max(window_len,1); tmo <= arm_timeout; done <= 0; timed_out <= 0; next state CLEAR.
  - A start in other states, or with cfg_enable == 0, is ignored.
- CLEAR: cnt_clear = act_mask for exactly CLEAR_CYCLES cycles.
  - Then go to ARM if trg_mask != 0, else RUN.
- ARM: each cycle test (trig_in & trg_mask) != 0.
  - Hit: go to RUN, and pulse trig_out in the first RUN cycle.
  - If tmo != 0 and ARM has lasted tmo cycles without a hit: timed_out <= 1, go to DONE; no snapshot, cnt_run never asserted.
  - A trigger in the same cycle as the timeout expiry wins (go to RUN).
- RUN: cnt_run = act_mask for exactly win cycles, then SNAP.
  - The window counter is WIN_W wide; window_len = 2^WIN_W-1 must not wrap.
- SNAP: cnt_snapshot = act_mask for one cycle, cnt_run = 0, then DONE.
- DONE: done = 1 and busy = 0, held until the next accepted start or abort.
- abort in any state → IDLE next cycle.
  - All strobes drop; done and timed_out are cleared.
  - abort beats a simultaneous start.
- Latency: start sampled at edge N → cnt_clear high from N+1 to N+CLEAR_CYCLES.
- cfg_* and window_len changes during a measurement have no effect, because they are latched at start.

Optional Feature:
- Macro SEQ_AUTO_REARM_EN.
- Defined:
  - On leaving SNAP, run_count increments, saturating at 16'hFFFF.
  - If cfg_rearm = 1 in SNAP, the next state is CLEAR instead of DONE, reusing the latched masks and lengths, and done is not asserted.
  - A timeout still goes to DONE.
  - run_count clears on an accepted start from IDLE/DONE and on abort.
- Undefined: cfg_rearm is ignored and run_count is tied to 0.

Decomposition:
- Package edge_seq_pkg holds:
  - the seq_state_t enum (values above);
  - SEQ_STATE_W = 3;
  - the default CLEAR_CYCLES.
- One sub-module, seq_down_counter: loadable WIN_W down-counter with load/enable/zero flag, shared by the ARM timeout and the RUN window.
  - One instance is enough, since ARM and RUN never overlap.

Test Plan:
- Basic run. Stimulus: cfg_enable=4'b0101, cfg_trig_enable=0, window_len=10, start pulse. Required: cnt_clear=0101 for 2 cycles; cnt_run=0101 for exactly 10 cycles; cnt_snapshot=0101 for 1 cycle; done=1; seq_state steps 1,3,4,5.
- Trigger arm. Stimulus: cfg_enable=4'hF, cfg_trig_enable=4'b0010, window_len=5, raise trig_in[0] then trig_in[1] 7 cycles after ARM entry. Required: trig_in[0] is ignored; RUN starts the cycle after trig_in[1] is sampled; trig_out pulses once; cnt_run lasts 5 cycles.
- Timeout. Stimulus: trigger mask set, arm_timeout=20, no trigger. Required: ARM lasts 20 cycles; timed_out=1; done=1; cnt_run and cnt_snapshot never asserted.
- Edge conditions. Stimulus: (a) abort and start in the same cycle during RUN; (b) start with cfg_enable=0; (c) window_len=0. Required: (a) IDLE next cycle, all strobes 0, the start is ignored; (b) stays IDLE; (c) cnt_run asserted for exactly 1 cycle.
- Reset during RUN. Stimulus: assert rst_n_sync low asynchronously. Required: all outputs 0 before the next clock edge; seq_state=0.
- Auto re-arm, with SEQ_AUTO_REARM_EN defined. Stimulus: cfg_rearm=1, window_len=3. Required: SNAP→CLEAR repeats; run_count increments 1,2,3; done stays 0; dropping cfg_rearm ends in DONE.
